// File: rtl/bcd_timer_pkg.sv
// ============================================================================
// Module  : bcd_timer_pkg
// Brief   : Shared constants and FSM state type for the BCD countdown timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_timer_pkg;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module  : bcd_down_digit
// Brief   : One BCD decade of the down counter; wraps 0 -> 9 with a borrow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_digit,
  input  logic               i_borrow_in,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_borrow_out
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_digit;
    end else if (i_borrow_in) begin
      r_digit <= (r_digit == '0) ? BCD_MAX : (r_digit - 4'd1);
    end
  end

  // Borrow is combinational so the whole chain ripples in one cycle.
  assign o_borrow_out = i_borrow_in && (r_digit == '0);
  assign o_digit      = r_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module  : bcd_countdown_timer
// Brief   : Multi-decade BCD countdown timer with load validation and expiry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic [4*DIGITS-1:0]     i_load_value,
  input  logic                    i_start,
  input  logic                    i_pause,
  input  logic                    i_tick,
  output logic [4*DIGITS-1:0]     o_count,
  output logic                    o_running,
  output logic                    o_zero,
  output logic                    o_expired,
  output logic                    o_load_err
);

  localparam int                c_count_w = DIGIT_W * DIGITS;
  localparam logic [c_count_w-1:0] c_one  = {{(c_count_w-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_expired;
  logic                  r_load_err;
  logic                  w_load_ok;
  logic                  w_dec;
  logic                  w_is_one;
  logic [DIGITS:0]       w_borrow;
  logic [c_count_w-1:0]  w_count;
  logic                  w_unused_borrow;

  always_comb begin
    w_load_ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_load_value[d*DIGIT_W +: DIGIT_W] > BCD_MAX) w_load_ok = 1'b0;
    end
  end

  assign w_is_one = (w_count == c_one);
  assign o_zero   = (w_count == '0);

  // A qualified tick: RUN, no pause or load this cycle, and never below zero.
  assign w_dec = (r_state == RUN) && i_tick && !i_pause && !i_load && !o_zero;

  assign w_borrow[0]     = w_dec;
  assign w_unused_borrow = w_borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk          (clk),
      .reset        (reset),
      .i_load       (i_load && w_load_ok),
      .i_load_digit (i_load_value[g*DIGIT_W +: DIGIT_W]),
      .i_borrow_in  (w_borrow[g]),
      .o_digit      (w_count[g*DIGIT_W +: DIGIT_W]),
      .o_borrow_out (w_borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_expired  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_expired  <= 1'b0;
      r_load_err <= 1'b0;
      if (i_load) begin
        if (w_load_ok) r_state    <= IDLE;
        else           r_load_err <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !o_zero) r_state <= RUN;
          end
          RUN: begin
            if (i_pause) begin
              r_state <= PAUSED;
            end else if (i_tick && w_is_one) begin
              r_state   <= IDLE;
              r_expired <= 1'b1;
            end
          end
          PAUSED: begin
            if (i_start) r_state <= RUN;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_count    = w_count;
  assign o_running  = (r_state == RUN);
  assign o_expired  = r_expired;
  assign o_load_err = r_load_err;

endmodule

`default_nettype wire
